// File: rtl/alu_8_bit.sv
// Registered 8-bit ALU: add, subtract, AND and OR on unsigned bytes, with
// carry/borrow and zero flags presented one cycle after an accepted operation.
module alu_8_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [1:0] opcode,
  output logic [7:0] y,
  output logic       carryout,
  output logic       zero,
  output logic       out_valid
);

  typedef enum logic [1:0] {
    OpAdd = 2'b00,
    OpSub = 2'b01,
    OpAnd = 2'b10,
    OpOr  = 2'b11
  } op_e;

  logic [8:0] res_d;
  logic [7:0] y_q;
  logic       carry_q;
  logic       zero_q;
  logic       valid_q;

  // Bit 8 carries the ADD carry-out; for SUB the 9-bit wrap sets it exactly on borrow.
  always_comb begin
    res_d = 9'd0;
    unique case (op_e'(opcode))
      OpAdd:   res_d = {1'b0, a} + {1'b0, b};
      OpSub:   res_d = {1'b0, a} - {1'b0, b};
      OpAnd:   res_d = {1'b0, a & b};
      OpOr:    res_d = {1'b0, a | b};
      default: res_d = 9'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q     <= 8'h00;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        y_q     <= res_d[7:0];
        carry_q <= res_d[8];
        zero_q  <= (res_d[7:0] == 8'h00);
      end
    end
  end

  assign y         = y_q;
  assign carryout  = carry_q;
  assign zero      = zero_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_alu_8_bit.sv
// Self-checking bench for alu_8_bit: directed cases, hold, reset and random
// traffic compared against a plain-arithmetic reference model.
module tb_alu_8_bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] opcode;
  logic [7:0] y;
  logic       carryout;
  logic       zero;
  logic       out_valid;

  int checks = 0;
  int errors = 0;

  int exp_y;
  int exp_c;
  int exp_z;
  int exp_v;

  alu_8_bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .opcode    (opcode),
    .y         (y),
    .carryout  (carryout),
    .zero      (zero),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, ".y"}, {24'd0, y}, exp_y);
    check({tag, ".carry"}, {31'd0, carryout}, exp_c);
    check({tag, ".zero"}, {31'd0, zero}, exp_z);
    check({tag, ".valid"}, {31'd0, out_valid}, exp_v);
    check({tag, ".zinv"}, {31'd0, zero}, {31'd0, (y == 8'h00)});
  endtask

  task automatic model_reset();
    exp_y = 0;
    exp_c = 0;
    exp_z = 1;
    exp_v = 0;
  endtask

  // Reference: integer arithmetic straight from the operation rules.
  task automatic model(input logic v, input int ia, input int ib, input int op);
    int r;
    exp_v = v ? 1 : 0;
    if (v) begin
      case (op)
        0: begin r = ia + ib; exp_c = (r > 255) ? 1 : 0; exp_y = r % 256; end
        1: begin r = ia - ib; exp_c = (r < 0) ? 1 : 0;   exp_y = (r + 256) % 256; end
        2: begin exp_c = 0; exp_y = ia & ib; end
        default: begin exp_c = 0; exp_y = ia | ib; end
      endcase
      exp_z = (exp_y == 0) ? 1 : 0;
    end
  endtask

  // Drive on the falling edge, let one rising edge sample, check on the next falling edge.
  task automatic step(input string tag, input logic v, input int ia, input int ib,
                      input int op);
    in_valid = v;
    a        = 8'(ia);
    b        = 8'(ib);
    opcode   = 2'(op);
    @(posedge clk);
    model(v, ia, ib, op);
    @(negedge clk);
    check_outs(tag);
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b1;
    a        = 8'd10;
    b        = 8'd20;
    opcode   = 2'b00;
    model_reset();
    #1;
    check_outs("rst_async");
    repeat (2) @(negedge clk);
    check_outs("rst_held");
    rst = 1'b0;

    step("add", 1, 10, 20, 0);
    step("add_ovf", 1, 200, 100, 0);
    step("add_80", 1, 8'h80, 8'h80, 0);
    step("sub", 1, 50, 20, 1);
    step("sub_borrow", 1, 20, 50, 1);
    step("sub_eq", 1, 77, 77, 1);
    step("and", 1, 8'b11001100, 8'b10101010, 2);
    step("or", 1, 8'b11001100, 8'b10101010, 3);
    step("and_zero", 1, 8'hF0, 8'h0F, 2);

    // Hold: operands change while in_valid is low
    step("hold_add", 1, 10, 20, 0);
    step("hold0", 0, 255, 1, 0);
    step("hold1", 0, 3, 9, 1);
    step("hold2", 0, 0, 0, 2);

    // Back-to-back stream
    step("b2b_add", 1, 100, 27, 0);
    step("b2b_sub", 1, 5, 6, 1);
    step("b2b_and", 1, 8'h3C, 8'h0F, 2);
    step("b2b_or", 1, 8'h00, 8'h00, 3);

    // Reset between edges, discarding the in-flight operation
    in_valid = 1'b1;
    a        = 8'd1;
    b        = 8'd2;
    opcode   = 2'b00;
    @(posedge clk);
    model(1, 1, 2, 0);
    #2;
    check_outs("pre_rst");
    rst = 1'b1;
    model_reset();
    #1;
    check_outs("mid_rst");
    @(negedge clk);
    check_outs("mid_rst_hold");
    rst = 1'b0;
    step("post_rst_idle", 0, 9, 9, 0);

    for (int i = 0; i < 300; i++) begin
      step("rand", ($urandom_range(0, 3) != 0), $urandom_range(0, 255),
           $urandom_range(0, 255), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
